// File: rtl/receive_comm_pkg.sv
// Shared serial-link definitions: FSM state encodings, default frame
// parameters and sample-point helpers. The transmit side reuses this package.
package receive_comm_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;

   // bsc value on the edge that lands mid start bit
   function automatic int unsigned start_sample(input int unsigned os);
      return (os / 2) - 1;
   endfunction

   // bsc value on the edge that lands mid data/parity/stop bit
   function automatic int unsigned bit_sample(input int unsigned os);
      return os - 1;
   endfunction

   localparam int unsigned START_SAMPLE = start_sample(OVERSAMPLE_DEF);
   localparam int unsigned BIT_SAMPLE   = bit_sample(OVERSAMPLE_DEF);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_e;

endpackage

// File: rtl/receive_comm_if.sv
// Receiver line/parallel bundle.
//   receive_en, serial_in       : line side, driven by the master
//   parallel_out, char_received,
//   framing_error, parity_error,
//   busy                        : receiver results, driven by the slave
interface receive_comm_if #(
   parameter int unsigned DATA_BITS = receive_comm_pkg::DATA_BITS_DEF
);
   logic                 receive_en;
   logic                 serial_in;
   logic [DATA_BITS-1:0] parallel_out;
   logic                 char_received;
   logic                 framing_error;
   logic                 parity_error;
   logic                 busy;

   modport master (
      output receive_en, serial_in,
      input  parallel_out, char_received, framing_error, parity_error, busy
   );

   modport slave (
      input  receive_en, serial_in,
      output parallel_out, char_received, framing_error, parity_error, busy
   );
endinterface

// File: rtl/receive_comm_rx_sample_counter.sv
// Bit-sample counter (bsc): counts oversample ticks within a bit, wrapping
// naturally, and flags the mid-start-bit and mid-bit sample points.
//   clk, reset  : clock, synchronous active-high reset
//   clr         : force bsc to 0 (priority over en)
//   en          : advance bsc
//   start_tc_c  : bsc == START_SAMPLE
//   bit_tc_c    : bsc == BIT_SAMPLE
module rx_sample_counter
   import receive_comm_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic start_tc_c,
   output logic bit_tc_c
);
   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] START_TC = CNT_W'(start_sample(OVERSAMPLE));
   localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(bit_sample(OVERSAMPLE));

   logic [CNT_W-1:0] bsc_q, bsc_d;

   // next count
   always_comb begin
      bsc_d = bsc_q;
      if (clr) begin
         bsc_d = '0;
      end else if (en) begin
         bsc_d = bsc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bsc_q <= '0;
      end else begin
         bsc_q <= bsc_d;
      end
   end

   assign start_tc_c = (bsc_q == START_TC);
   assign bit_tc_c   = (bsc_q == BIT_TC);

endmodule

// File: rtl/receive_comm.sv
// Serial-to-parallel receiver. Idle-high line, frame = start(0), DATA_BITS
// data bits LSB first, [even parity], stop(1); each bit OVERSAMPLE clk cycles.
// Samples mid-bit, loads parallel_out with a one-cycle char_received strobe,
// flags bad stop bits and then waits in BREAK until the line returns high.
//   clk, reset : clock / oversample tick, synchronous active-high reset
//   rx         : receive_comm_if.slave (receive_en, serial_in in; results out)
// Optional feature: define RX_PARITY_EN to add an even-parity bit before stop.
module receive_comm
   import receive_comm_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
   input  logic           clk,
   input  logic           reset,
   receive_comm_if.slave  rx
);
   localparam int unsigned BIC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [BIC_W-1:0]     bic_q, bic_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] pout_q, pout_d;
   logic                 char_q, char_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;
`ifdef RX_PARITY_EN
   logic                 pbit_q, pbit_d;
   logic                 perr_q, perr_d;
`endif

   logic cnt_clr_c, cnt_en_c, start_tc_c, bit_tc_c;

   rx_sample_counter #(.OVERSAMPLE(OVERSAMPLE)) u_bsc (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr_c),
      .en         (cnt_en_c),
      .start_tc_c (start_tc_c),
      .bit_tc_c   (bit_tc_c)
   );

   // next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      bic_d   = bic_q;
      shift_d = shift_q;
      pout_d  = pout_q;
      char_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
      pbit_d  = pbit_q;
      perr_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (rx.receive_en && !rx.serial_in) state_d = START;
         end
         START: begin
            if (start_tc_c) begin
               if (!rx.serial_in) begin
                  state_d = DATA;
                  bic_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (bit_tc_c) begin
               // new bit enters at the MSB; after DATA_BITS shifts bit 0 sits at the LSB
               shift_d = {rx.serial_in, shift_q[DATA_BITS-1:1]};
               bic_d   = bic_q + BIC_W'(1);
               if (bic_q == BIC_LAST) begin
`ifdef RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (bit_tc_c) begin
               pbit_d  = rx.serial_in;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_tc_c) begin
               if (rx.serial_in) begin
                  pout_d  = shift_q;
                  char_d  = 1'b1;
`ifdef RX_PARITY_EN
                  perr_d  = (^shift_q) ^ pbit_q;
`endif
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx.serial_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // disarming aborts any frame in flight, even on its stop sample
      if (!rx.receive_en && (state_q != IDLE)) begin
         state_d = IDLE;
         shift_d = '0;
         pout_d  = pout_q;
         char_d  = 1'b0;
         ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end

      busy_d = (state_d != IDLE);

      // bsc restarts at every state change so each state times from its entry
      cnt_clr_c = (state_q == IDLE) || (state_q == BREAK) || (state_d != state_q);
      cnt_en_c  = (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bic_q   <= '0;
         shift_q <= '0;
         pout_q  <= '0;
         char_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
         pbit_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bic_q   <= bic_d;
         shift_q <= shift_d;
         pout_q  <= pout_d;
         char_q  <= char_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef RX_PARITY_EN
         pbit_q  <= pbit_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx.parallel_out  = pout_q;
   assign rx.char_received = char_q;
   assign rx.framing_error = ferr_q;
   assign rx.busy          = busy_q;
`ifdef RX_PARITY_EN
   assign rx.parity_error  = perr_q;
`else
   assign rx.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_receive_comm.sv
module tb_receive_comm;

`ifdef RX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif
   localparam int OS  = 16;
   localparam int NB  = PAR_ON ? 11 : 10;   // bits per frame
   localparam int FL  = OS * NB;            // frame length in cycles
   localparam int LAT = FL - OS / 2;        // start edge -> stop sample edge

   typedef struct {
      int         cyc;
      bit         cr;
      bit         fe;
      bit         pe;
      logic [7:0] po;
   } ev_t;

   typedef struct {
      logic [7:0] d;
      bit         stop_b;
      bit         flip;
      logic [7:0] exp_po;
      bit         exp_cr;
      bit         exp_fe;
      bit         exp_pe;
   } vec_t;

   logic clk;
   logic reset;
   receive_comm_if #(.DATA_BITS(8)) u_if ();

   receive_comm #(.OVERSAMPLE(OS), .DATA_BITS(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .rx    (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  busy_cnt = 0;
   ev_t ev_q[$];
   ev_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // one clock edge; outputs observed 1 time unit later, strobes logged
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (u_if.busy) busy_cnt++;
      if (u_if.char_received || u_if.framing_error || u_if.parity_error)
         ev_q.push_back('{cyc, u_if.char_received, u_if.framing_error,
                          u_if.parity_error, u_if.parallel_out});
   endtask

   task automatic idle(input int n);
      u_if.serial_in = 1'b1;
      repeat (n) tick();
   endtask

   // drive one frame; receive_en low from abort_off onward (if >= 0); stop after max_cyc
   task automatic run_frame(input logic [7:0] d, input bit stop_b, input bit flip,
                            input int abort_off, input int max_cyc, output int sc);
      logic [10:0] fb;
      int ncyc;
      fb = '1;
      fb[0] = 1'b0;
      fb[8:1] = d;
      if (PAR_ON) begin
         fb[9]  = (^d) ^ flip;
         fb[10] = stop_b;
      end else begin
         fb[9] = stop_b;
      end
      ncyc = (max_cyc < FL) ? max_cyc : FL;
      sc = -1;
      for (int k = 0; k < ncyc; k++) begin
         u_if.serial_in  = fb[k / OS];
         u_if.receive_en = !(abort_off >= 0 && k >= abort_off);
         tick();
         if (k == 0) sc = cyc;
      end
      u_if.receive_en = 1'b1;
   endtask

   vec_t tbl[7];

   initial begin
      int sc, sc2, n, gap;
      logic [7:0] last_good, d;
      bit stop_b, flip;

      tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, PAR_ON};
      tbl[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'h3C, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};

      reset = 1'b1;
      u_if.receive_en = 1'b1;
      u_if.serial_in  = 1'b1;
      repeat (3) tick();
      chk("reset_po",   u_if.parallel_out,  0);
      chk("reset_cr",   u_if.char_received, 0);
      chk("reset_fe",   u_if.framing_error, 0);
      chk("reset_pe",   u_if.parity_error,  0);
      chk("reset_busy", u_if.busy,          0);
      reset = 1'b0;
      idle(5);

      // table-driven single frames
      for (int i = 0; i < 7; i++) begin
         ev_q.delete();
         busy_cnt = 0;
         run_frame(tbl[i].d, tbl[i].stop_b, tbl[i].flip, -1, FL, sc);
         idle(24);
         chk($sformatf("vec%0d_events", i), ev_q.size(),
             (tbl[i].exp_cr || tbl[i].exp_fe) ? 1 : 0);
         if (ev_q.size() > 0) begin
            chk($sformatf("vec%0d_cycle", i), ev_q[0].cyc - sc, LAT);
            chk($sformatf("vec%0d_cr", i), ev_q[0].cr, tbl[i].exp_cr);
            chk($sformatf("vec%0d_fe", i), ev_q[0].fe, tbl[i].exp_fe);
            chk($sformatf("vec%0d_pe", i), ev_q[0].pe, tbl[i].exp_pe);
         end
         chk($sformatf("vec%0d_po", i), u_if.parallel_out, tbl[i].exp_po);
         chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, tbl[i].exp_fe ? FL : LAT);
      end

      // glitch: 4 low cycles is a false start
      ev_q.delete();
      busy_cnt = 0;
      u_if.serial_in = 1'b0;
      repeat (4) tick();
      idle(20);
      chk("glitch_events", ev_q.size(), 0);
      chk("glitch_busy_cycles", busy_cnt, 8);
      chk("glitch_po", u_if.parallel_out, 8'h81);

      // bad stop then line held low: stays in BREAK until the line rises
      ev_q.delete();
      run_frame(8'h3C, 1'b0, 1'b0, -1, FL, sc);
      u_if.serial_in = 1'b0;
      repeat (50) tick();
      chk("break_busy_held", u_if.busy, 1);
      chk("break_events", ev_q.size(), 1);
      chk("break_po", u_if.parallel_out, 8'h81);
      idle(1);
      chk("break_exit_busy", u_if.busy, 0);
      idle(10);
      run_frame(8'h55, 1'b1, 1'b0, -1, FL, sc);
      idle(20);
      chk("after_break_po", u_if.parallel_out, 8'h55);
      chk("after_break_events", ev_q.size(), 2);

      // reset in the middle of data bit 3 of 0x81
      ev_q.delete();
      run_frame(8'h81, 1'b1, 1'b0, -1, OS * 4 + OS / 2, sc);
      reset = 1'b1;
      u_if.serial_in = 1'b1;
      tick();
      chk("midreset_po",   u_if.parallel_out,  0);
      chk("midreset_cr",   u_if.char_received, 0);
      chk("midreset_fe",   u_if.framing_error, 0);
      chk("midreset_pe",   u_if.parity_error,  0);
      chk("midreset_busy", u_if.busy,          0);
      reset = 1'b0;
      idle(10);
      run_frame(8'h3C, 1'b1, 1'b0, -1, FL, sc);
      idle(20);
      chk("midreset_events", ev_q.size(), 1);
      chk("midreset_next_po", u_if.parallel_out, 8'h3C);

      // back-to-back frames, no idle gap
      ev_q.delete();
      run_frame(8'h00, 1'b1, 1'b0, -1, FL, sc);
      run_frame(8'hFF, 1'b1, 1'b0, -1, FL, sc2);
      idle(20);
      chk("b2b_events", ev_q.size(), 2);
      if (ev_q.size() == 2) begin
         chk("b2b_first_cycle", ev_q[0].cyc - sc, LAT);
         chk("b2b_spacing", ev_q[1].cyc - ev_q[0].cyc, FL);
         chk("b2b_first_po", ev_q[0].po, 8'h00);
         chk("b2b_second_po", ev_q[1].po, 8'hFF);
      end

      // receive_en drop on the stop sample edge, and mid-data
      ev_q.delete();
      run_frame(8'h5A, 1'b1, 1'b0, LAT, FL, sc);
      idle(4);
      chk("abort_stop_events", ev_q.size(), 0);
      chk("abort_stop_po", u_if.parallel_out, 8'hFF);
      chk("abort_stop_busy", u_if.busy, 0);
      run_frame(8'hC3, 1'b1, 1'b0, 40, FL, sc);
      idle(4);
      chk("abort_data_events", ev_q.size(), 0);
      chk("abort_data_busy", u_if.busy, 0);
      idle(10);

      // randomized frames against a frame-level reference model
      ev_q.delete();
      exp_q.delete();
      last_good = 8'hFF;
      for (int i = 0; i < 30; i++) begin
         d      = 8'($urandom);
         stop_b = ($urandom_range(0, 5) != 0);
         flip   = 1'($urandom_range(0, 1));
         gap    = $urandom_range(0, 12);
         if (!stop_b && gap == 0) gap = 1;
         run_frame(d, stop_b, flip, -1, FL, sc);
         if (stop_b) last_good = d;
         exp_q.push_back('{sc + LAT, stop_b, !stop_b, PAR_ON && flip && stop_b, last_good});
         idle(gap);
      end
      idle(20);
      chk("rand_events", ev_q.size(), exp_q.size());
      n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("rand%0d_cycle", i), ev_q[i].cyc, exp_q[i].cyc);
         chk($sformatf("rand%0d_cr", i), ev_q[i].cr, exp_q[i].cr);
         chk($sformatf("rand%0d_fe", i), ev_q[i].fe, exp_q[i].fe);
         chk($sformatf("rand%0d_pe", i), ev_q[i].pe, exp_q[i].pe);
         chk($sformatf("rand%0d_po", i), ev_q[i].po, exp_q[i].po);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
